// File: rtl/fnd_scan_ctrl.sv
// Four-digit FND scan sequencer with frame-aligned double-buffered digit updates.
// Optional leading-zero blanking is enabled by defining FND_LZ_BLANK_EN.
module fnd_scan_ctrl #(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCAN_HZ    = 4_000,
  parameter int DIV        = SYS_CLK_HZ / SCAN_HZ
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  output logic        o_pending,
  output logic [1:0]  o_digitsel,
  output logic [3:0]  o_outdigit,
  output logic [3:0]  o_bcd,
  output logic        o_blank,
  output logic        o_frame_tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic [15:0]   active, shadow;
  logic          scan_tick, fb;

  assign scan_tick = (presc == PW'(DIV - 1));
  assign fb        = scan_tick && (o_digitsel == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      presc        <= '0;
      o_digitsel   <= 2'd0;
      active       <= 16'h0000;
      shadow       <= 16'h0000;
      o_pending    <= 1'b0;
      o_frame_tick <= 1'b0;
    end else begin
      presc        <= scan_tick ? '0 : presc + PW'(1);
      o_frame_tick <= fb;
      if (scan_tick) o_digitsel <= o_digitsel + 2'd1;
      // A load landing on the boundary bypasses the shadow and wins outright.
      if (fb) begin
        if (i_load) begin
          active    <= i_bcd;
          o_pending <= 1'b0;
        end else if (o_pending) begin
          active    <= shadow;
          o_pending <= 1'b0;
        end
      end else if (i_load) begin
        shadow    <= i_bcd;
        o_pending <= 1'b1;
      end
    end
  end

  assign o_bcd = active[4*o_digitsel +: 4];

  logic [3:0] anode;
  always_comb begin
    anode = 4'b1110;
    case (o_digitsel)
      2'd0: anode = 4'b1110;
      2'd1: anode = 4'b1101;
      2'd2: anode = 4'b1011;
      2'd3: anode = 4'b0111;
      default: anode = 4'b1110;
    endcase
  end

`ifdef FND_LZ_BLANK_EN
  logic [3:0] zero, lz;
  for (genvar k = 0; k < 4; k++) begin : g_zero
    assign zero[k] = (active[4*k +: 4] == 4'd0);
  end
  // A digit is a leading zero only if it and every digit above it are zero.
  assign lz[3] = zero[3];
  assign lz[2] = zero[2] & lz[3];
  assign lz[1] = zero[1] & lz[2];
  assign lz[0] = 1'b0;

  assign o_blank    = lz[o_digitsel];
  assign o_outdigit = o_blank ? 4'b1111 : anode;
`else
  assign o_blank    = 1'b0;
  assign o_outdigit = anode;
`endif

endmodule
